// File: rtl/core_pkg.sv
// Shared core definitions: register address width, x0 and drain states.
// Used by the issue controller and its scoreboard.
package core_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } drain_state_e;

  // True when a register address names a tracked (non-x0) register
  function automatic logic reg_nz(input logic [REG_ADDR_W-1:0] a);
    return a != X0;
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Register scoreboard: pending bits, in-flight write counter, hazard query.
// ID_ISSUE_WB_BYPASS_EN lets a same-cycle retire hide the pending bit.
module id_scoreboard
  import core_pkg::*;
#(
  parameter int NREGS   = 32,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] q_rs1,
  input  logic [REG_ADDR_W-1:0] q_rs2,
  input  logic [REG_ADDR_W-1:0] q_rd,
  output logic                  q_pend_rs1,
  output logic                  q_pend_rs2,
  output logic                  q_pend_rd,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic [CNT_W-1:0]      cnt_chk,
  output logic [CNT_W-1:0]      cnt_ret,
  output logic [NREGS-1:0]      pending_mask,
  output logic [CNT_W-1:0]      outstanding
);

  logic [NREGS-1:0] r_pend;
  logic [CNT_W-1:0] r_cnt;
  logic [NREGS-1:0] w_set_vec;
  logic [NREGS-1:0] w_clr_vec;
  logic [NREGS-1:0] w_pend_nxt;
  logic             w_ret;
  logic             w_byp1;
  logic             w_byp2;
  logic             w_bypd;

  // Retire only counts when it hits a register that is actually pending
  assign w_ret = wb_valid & reg_nz(wb_rd) & r_pend[wb_rd];

  assign cnt_ret = r_cnt - {{(CNT_W-1){1'b0}}, w_ret};

`ifdef ID_ISSUE_WB_BYPASS_EN
  assign w_byp1  = wb_valid & (q_rs1 == wb_rd);
  assign w_byp2  = wb_valid & (q_rs2 == wb_rd);
  assign w_bypd  = wb_valid & (q_rd == wb_rd);
  assign cnt_chk = cnt_ret;
`else
  assign w_byp1  = 1'b0;
  assign w_byp2  = 1'b0;
  assign w_bypd  = 1'b0;
  assign cnt_chk = r_cnt;
`endif

  assign q_pend_rs1 = reg_nz(q_rs1) & r_pend[q_rs1] & ~w_byp1;
  assign q_pend_rs2 = reg_nz(q_rs2) & r_pend[q_rs2] & ~w_byp2;
  assign q_pend_rd  = reg_nz(q_rd) & r_pend[q_rd] & ~w_bypd;

  // Decode set/clear one-hots; bit 0 is never tracked
  always_comb begin
    w_set_vec = '0;
    w_clr_vec = '0;
    for (int i = 1; i < NREGS; i++) begin
      w_set_vec[i] = set_en & (set_rd == REG_ADDR_W'(i));
      w_clr_vec[i] = w_ret & (wb_rd == REG_ADDR_W'(i));
    end
    w_pend_nxt    = (r_pend & ~w_clr_vec) | w_set_vec;
    w_pend_nxt[0] = 1'b0;
  end

  // Pending vector update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pend <= '0;
    else     r_pend <= w_pend_nxt;
  end

  // In-flight counter: +1 on tracked issue, -1 on real retire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      unique case ({set_en, w_ret})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign pending_mask = r_pend;
  assign outstanding  = r_cnt;

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode-to-execute issue gate with RAW/WAW/full checks and drain FSM.
// Optional same-cycle writeback bypass: define ID_ISSUE_WB_BYPASS_EN.
module id_issue_ctrl
  import core_pkg::*;
#(
  parameter int NREGS   = 32,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic                  dec_use_rs1,
  input  logic                  dec_use_rs2,
  input  logic                  dec_wr_rd,
  output logic                  dec_ready,
  output logic                  issue_fire,
  input  logic                  flush,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  drain_req,
  output logic                  drain_busy,
  output logic                  drain_done,
  output logic [NREGS-1:0]      pending_mask,
  output logic [CNT_W-1:0]      outstanding
);

  drain_state_e     r_state;
  drain_state_e     w_state_nxt;
  logic             w_p1;
  logic             w_p2;
  logic             w_pd;
  logic             w_raw1;
  logic             w_raw2;
  logic             w_waw;
  logic             w_wr_nz;
  logic             w_full;
  logic             w_set;
  logic [CNT_W-1:0] w_cnt_chk;
  logic [CNT_W-1:0] w_cnt_ret;

  id_scoreboard #(
    .NREGS   (NREGS),
    .MAX_OUT (MAX_OUT),
    .CNT_W   (CNT_W)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .q_rs1        (dec_rs1),
    .q_rs2        (dec_rs2),
    .q_rd         (dec_rd),
    .q_pend_rs1   (w_p1),
    .q_pend_rs2   (w_p2),
    .q_pend_rd    (w_pd),
    .set_en       (w_set),
    .set_rd       (dec_rd),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .cnt_chk      (w_cnt_chk),
    .cnt_ret      (w_cnt_ret),
    .pending_mask (pending_mask),
    .outstanding  (outstanding)
  );

  assign w_wr_nz = dec_wr_rd & reg_nz(dec_rd);
  assign w_raw1  = dec_use_rs1 & w_p1;
  assign w_raw2  = dec_use_rs2 & w_p2;
  assign w_waw   = dec_wr_rd & w_pd;
  assign w_full  = (w_cnt_chk == CNT_W'(MAX_OUT)) & w_wr_nz;

  assign dec_ready = ~w_raw1 & ~w_raw2 & ~w_waw & ~w_full
                   & ~flush & (r_state == ST_IDLE);
  assign issue_fire = dec_valid & dec_ready;
  assign w_set      = issue_fire & w_wr_nz;

  // Drain sequencing: wait for the counter to empty, then pulse done
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (drain_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_cnt_ret == '0) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Drain state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  assign drain_busy = (r_state == ST_DRAIN);
  assign drain_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Bench for id_issue_ctrl: vector table, drain/reset sequences, random
// stimulus against a per-register reference model.
module tb_id_issue_ctrl;

  localparam int NREGS   = 32;
  localparam int MAX_OUT = 4;
  localparam int CNT_W   = 4;
`ifdef ID_ISSUE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             dec_valid;
  logic [4:0]       dec_rs1;
  logic [4:0]       dec_rs2;
  logic [4:0]       dec_rd;
  logic             dec_use_rs1;
  logic             dec_use_rs2;
  logic             dec_wr_rd;
  logic             dec_ready;
  logic             issue_fire;
  logic             flush;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             drain_req;
  logic             drain_busy;
  logic             drain_done;
  logic [NREGS-1:0] pending_mask;
  logic [CNT_W-1:0] outstanding;

  id_issue_ctrl #(
    .NREGS   (NREGS),
    .MAX_OUT (MAX_OUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dec_valid    (dec_valid),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rd       (dec_rd),
    .dec_use_rs1  (dec_use_rs1),
    .dec_use_rs2  (dec_use_rs2),
    .dec_wr_rd    (dec_wr_rd),
    .dec_ready    (dec_ready),
    .issue_fire   (issue_fire),
    .flush        (flush),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .drain_req    (drain_req),
    .drain_busy   (drain_busy),
    .drain_done   (drain_done),
    .pending_mask (pending_mask),
    .outstanding  (outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: which registers await a write, how many, drain phase
  bit m_pend[NREGS];
  int m_cnt;
  int m_mode; // 0 idle, 1 draining, 2 done pulse

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) m_pend[r] = 1'b0;
    m_cnt  = 0;
    m_mode = 0;
  endtask

  function automatic bit m_ret();
    return wb_valid && wb_rd != 0 && m_pend[wb_rd];
  endfunction

  function automatic bit m_busy_reg(input logic [4:0] r);
    if (r == 0) return 1'b0;
    if (BYP && wb_valid && wb_rd == r) return 1'b0;
    return m_pend[r];
  endfunction

  function automatic bit m_ready();
    int cc;
    bit blocked;
    cc = m_cnt - ((BYP && m_ret()) ? 1 : 0);
    blocked = (dec_use_rs1 && m_busy_reg(dec_rs1))
           || (dec_use_rs2 && m_busy_reg(dec_rs2))
           || (dec_wr_rd && m_busy_reg(dec_rd))
           || (cc == MAX_OUT && dec_wr_rd && dec_rd != 0)
           || flush || m_mode != 0;
    return !blocked;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] mk;
    mk = '0;
    for (int r = 1; r < NREGS; r++) mk[r] = m_pend[r];
    return mk;
  endfunction

  logic        s_ready, s_fire, s_busy, s_done;
  logic [31:0] s_mask;
  logic [3:0]  s_out;

  task automatic drive(input int v, input int rs1, input int u1,
                       input int rs2, input int u2, input int rd,
                       input int wr, input int fl, input int wbv,
                       input int wbrd, input int dreq);
    dec_valid   = 1'(v);
    dec_rs1     = 5'(rs1);
    dec_use_rs1 = 1'(u1);
    dec_rs2     = 5'(rs2);
    dec_use_rs2 = 1'(u2);
    dec_rd      = 5'(rd);
    dec_wr_rd   = 1'(wr);
    flush       = 1'(fl);
    wb_valid    = 1'(wbv);
    wb_rd       = 5'(wbrd);
    drain_req   = 1'(dreq);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock: compare at negedge, advance the model at posedge
  task automatic run_cycle(input string tag);
    bit e_ready, e_fire, rt;
    int cnt_after;
    @(negedge clk);
    s_ready = dec_ready;
    s_fire  = issue_fire;
    s_busy  = drain_busy;
    s_done  = drain_done;
    s_mask  = pending_mask;
    s_out   = outstanding;
    e_ready = m_ready();
    e_fire  = dec_valid && e_ready;
    chk({tag, "/ready"}, 32'(s_ready), 32'(e_ready));
    chk({tag, "/fire"}, 32'(s_fire), 32'(e_fire));
    chk({tag, "/mask"}, s_mask, m_mask());
    chk({tag, "/outstanding"}, 32'(s_out), 32'(m_cnt));
    chk({tag, "/busy"}, 32'(s_busy), 32'(m_mode == 1));
    chk({tag, "/done"}, 32'(s_done), 32'(m_mode == 2));
    @(posedge clk);
    rt = m_ret();
    cnt_after = m_cnt - (rt ? 1 : 0);
    if (rt) begin
      m_pend[wb_rd] = 1'b0;
      m_cnt--;
    end
    if (e_fire && dec_wr_rd && dec_rd != 0) begin
      m_pend[dec_rd] = 1'b1;
      m_cnt++;
    end
    case (m_mode)
      0: if (drain_req) m_mode = 1;
      1: if (cnt_after == 0) m_mode = 2;
      default: m_mode = 0;
    endcase
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    #2;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    int v, rs1, u1, rd, wr, fl, wbv, wbrd;
    logic        e_ready;
    logic [31:0] e_mask;
    logic [3:0]  e_out;
  } vec_t;

  function automatic vec_t mk(input int v, input int rs1, input int u1,
                              input int rd, input int wr, input int fl,
                              input int wbv, input int wbrd,
                              input int er, input int em, input int eo);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.u1 = u1; t.rd = rd; t.wr = wr;
    t.fl = fl; t.wbv = wbv; t.wbrd = wbrd;
    t.e_ready = 1'(er);
    t.e_mask  = 32'(em);
    t.e_out   = 4'(eo);
    return t;
  endfunction

  vec_t tbl[31];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int done_cnt;
    int pl[$];
    model_reset();
    idle();
    rst = 1'b1;
    do_reset();

    // v rs1 u1 rd wr fl wbv wbrd | ready mask out (mask/out pre-edge)
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h00, 0);
    tbl[1]  = mk(1, 0, 0, 5, 1, 0, 0, 0, 1, 'h00, 0);
    tbl[2]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 'h20, 1);
    tbl[3]  = mk(1, 5, 1, 0, 0, 0, 1, 5, 0, 'h20, 1);
    tbl[4]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 1, 'h00, 0);
    tbl[5]  = mk(1, 0, 1, 0, 1, 0, 0, 0, 1, 'h00, 0);
    tbl[6]  = mk(1, 0, 1, 0, 1, 0, 0, 0, 1, 'h00, 0);
    tbl[7]  = mk(1, 0, 0, 1, 1, 0, 0, 0, 1, 'h00, 0);
    tbl[8]  = mk(1, 0, 0, 2, 1, 0, 0, 0, 1, 'h02, 1);
    tbl[9]  = mk(1, 0, 0, 3, 1, 0, 0, 0, 1, 'h06, 2);
    tbl[10] = mk(1, 0, 0, 4, 1, 0, 0, 0, 1, 'h0E, 3);
    tbl[11] = mk(1, 0, 0, 6, 1, 0, 0, 0, 0, 'h1E, 4);
    tbl[12] = mk(1, 0, 0, 6, 1, 0, 1, 2, 0, 'h1E, 4);
    tbl[13] = mk(1, 0, 0, 6, 1, 0, 0, 0, 1, 'h1A, 3);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h5A, 4);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 'h5A, 4);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 1, 3, 1, 'h58, 3);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 1, 4, 1, 'h50, 2);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 1, 6, 1, 'h40, 1);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 1, 9, 1, 'h00, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 'h00, 0);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h00, 0);
    tbl[22] = mk(1, 0, 0, 7, 1, 0, 0, 0, 1, 'h00, 0);
    tbl[23] = mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 'h80, 1);
    tbl[24] = mk(1, 0, 0, 7, 1, 0, 1, 7, 0, 'h80, 1);
    tbl[25] = mk(1, 0, 0, 7, 1, 0, 0, 0, 1, 'h00, 0);
    tbl[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h80, 1);
    tbl[27] = mk(0, 0, 0, 0, 0, 0, 1, 7, 1, 'h80, 1);
    tbl[28] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h00, 0);
    tbl[29] = mk(1, 0, 0, 8, 1, 1, 0, 0, 0, 'h00, 0);
    tbl[30] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h00, 0);

`ifndef ID_ISSUE_WB_BYPASS_EN
    for (int i = 0; i < 31; i++) begin
      string tg;
      tg = $sformatf("tbl%0d", i);
      drive(tbl[i].v, tbl[i].rs1, tbl[i].u1, 0, 0, tbl[i].rd,
            tbl[i].wr, tbl[i].fl, tbl[i].wbv, tbl[i].wbrd, 0);
      run_cycle(tg);
      chk({tg, "/t_ready"}, 32'(s_ready), 32'(tbl[i].e_ready));
      chk({tg, "/t_fire"}, 32'(s_fire),
          32'(tbl[i].e_ready & 1'(tbl[i].v)));
      chk({tg, "/t_mask"}, s_mask, tbl[i].e_mask);
      chk({tg, "/t_out"}, 32'(s_out), 32'(tbl[i].e_out));
    end
`endif

    // RAW on rs1 against the retiring register: bypass decides the stall
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    run_cycle("byp_issue");
    drive(1, 5, 1, 0, 0, 0, 0, 0, 1, 5, 0);
    run_cycle("byp_wb");
    chk("byp_ready_in_wb_cycle", 32'(s_ready), 32'(BYP));

    // Drain with two writes in flight
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    run_cycle("dr_i1");
    drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
    run_cycle("dr_i2");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    run_cycle("dr_req");
    chk("dr_busy_req_cycle", 32'(s_busy), 0);
    done_cnt = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle("dr_wait");
    chk("dr_busy", 32'(s_busy), 1);
    chk("dr_ready_blocked", 32'(s_ready), 0);
    chk("dr_out2", 32'(s_out), 2);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    run_cycle("dr_wb1");
    chk("dr_busy_wb1", 32'(s_busy), 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    run_cycle("dr_wb2");
    chk("dr_out1", 32'(s_out), 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      run_cycle("dr_tail");
      if (s_done) done_cnt++;
      if (k == 0) begin
        chk("dr_done_pulse", 32'(s_done), 1);
        chk("dr_ready_in_done", 32'(s_ready), 0);
      end
      if (k == 1) chk("dr_issue_resumes", 32'(s_fire), 1);
    end
    chk("dr_done_count", 32'(done_cnt), 1);

    // Reset while draining, then a flushed issue
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    run_cycle("rd_i1");
    drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 1);
    run_cycle("rd_i2");
    idle();
    run_cycle("rd_drain");
    chk("rd_busy_before", 32'(s_busy), 1);
    chk("rd_out_before", 32'(s_out), 2);
    rst = 1'b1;
    #2;
    chk("rd_mask_async", pending_mask, 0);
    chk("rd_out_async", 32'(outstanding), 0);
    chk("rd_busy_async", 32'(drain_busy), 0);
    chk("rd_done_async", 32'(drain_done), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      run_cycle("rd_after");
      if (s_done) done_cnt++;
    end
    chk("rd_no_done", 32'(done_cnt), 0);
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
    run_cycle("fl_cycle");
    chk("fl_no_fire", 32'(s_fire), 0);
    idle();
    run_cycle("fl_after");
    chk("fl_mask_clean", s_mask, 0);

    // Random traffic over a small register window
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int wbv, wbrd;
      if ($urandom_range(0, 599) == 0) do_reset();
      pl.delete();
      for (int r = 1; r < NREGS; r++) if (m_pend[r]) pl.push_back(r);
      if (pl.size() > 0 && $urandom_range(0, 2) != 0) begin
        wbv  = 1;
        wbrd = pl[$urandom_range(0, pl.size() - 1)];
      end else begin
        wbv  = ($urandom_range(0, 4) == 0) ? 1 : 0;
        wbrd = $urandom_range(0, 7);
      end
      drive(($urandom_range(0, 9) < 7) ? 1 : 0,
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1),
            ($urandom_range(0, 9) == 0) ? 1 : 0,
            wbv, wbrd,
            ($urandom_range(0, 29) == 0) ? 1 : 0);
      run_cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_issue_ctrl.md
Name: id_issue_ctrl

Overview:
Issue controller between the decode stage and execute. It keeps a register scoreboard of in-flight destination writes and gates decode-to-execute issue on RAW/WAW hazards and on an outstanding-write limit. It also sequences a drain (fence) operation. It consumes the rs1/rs2/rd fields produced by decode and retirement notifications from writeback.

Parameters:
NREGS, 32, architectural register count; x0 is never tracked.
MAX_OUT, 4, maximum simultaneous in-flight register writes (1..15).
CNT_W, 4, width of the outstanding counter; must satisfy 2^CNT_W > MAX_OUT.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
dec_valid  in  1  decode holds a valid instruction.
dec_rs1  in  5  source register 1 address.
dec_rs2  in  5  source register 2 address.
dec_rd  in  5  destination register address.
dec_use_rs1  in  1  instruction reads rs1.
dec_use_rs2  in  1  instruction reads rs2.
dec_wr_rd  in  1  instruction writes rd.
dec_ready  out  1  issue permitted this cycle (combinational).
issue_fire  out  1  dec_valid & dec_ready; instruction moves to execute.
flush  in  1  squash the decode slot this cycle; no issue occurs.
wb_valid  in  1  an in-flight write retires (also asserted for squashed in-flight ops).
wb_rd  in  5  retiring destination register.
drain_req  in  1  single-cycle fence request.
drain_busy  out  1  drain in progress.
drain_done  out  1  one-cycle pulse when the drain completes.
pending_mask  out  NREGS  scoreboard bits; bit 0 is always 0.
outstanding  out  CNT_W  count of in-flight writes.

Behaviour:
- Reset (async): pending_mask = 0, outstanding = 0, state IDLE, drain_busy = 0, drain_done = 0.
- Hazard terms: raw1 = dec_use_rs1 & rs1≠0 & pend[rs1]; raw2 is the same for rs2; waw = dec_wr_rd & rd≠0 & pend[rd].
- full = (outstanding == MAX_OUT) & dec_wr_rd & rd≠0.
- dec_ready = ~raw1 & ~raw2 & ~waw & ~full & ~flush & (state == IDLE).
- Issue: on issue_fire with dec_wr_rd and rd≠0, set pend[rd] next cycle and increment outstanding. A write to rd = 0 issues without touching the scoreboard.
- Retire: on wb_valid with wb_rd≠0, clear pend[wb_rd] and decrement outstanding.
  - wb_valid to an unpending register or rd = 0 is ignored; the counter never underflows.
- Same cycle issue + retire, different registers: set one bit, clear the other, outstanding unchanged.
- Same register in the same cycle cannot occur, because waw blocks issue.
- Latency: a hazard clears the cycle after the wb_valid edge (no same-cycle bypass unless the optional feature is enabled).
- FSM:
  - IDLE: drain_req -> DRAIN. drain_busy = 1 from the next cycle; issue is blocked while in DRAIN.
  - DRAIN: when outstanding == 0 (after applying this cycle's retire) -> DONE.
  - DONE: drain_done = 1 for exactly one cycle -> IDLE.
  - drain_req in DRAIN or DONE is ignored.
  - drain_req in the same cycle as an issue: the issue still happens, then DRAIN waits for it.
- flush has no effect on the scoreboard or FSM; squashed in-flight ops retire via wb_valid.
- Reset mid-drain returns to IDLE with no drain_done pulse.

Optional Feature:
ID_ISSUE_WB_BYPASS_EN.
- Defined: a source or destination whose register equals wb_rd with wb_valid set in the current cycle is treated as not pending. Issue can occur in the same cycle the producer retires; this requires register file write-before-read. The full check uses outstanding minus the retiring write.
- Undefined: no bypass; one extra stall cycle after retire.

Decomposition:
- Shared package (core_pkg): REG_ADDR_W = 5, the X0 constant, and an enum for drain states IDLE/DRAIN/DONE.
- One natural sub-module: id_scoreboard, holding the pending bit vector, set/clear logic and outstanding counter, with a hazard query interface.
- FSM and ready logic live in id_issue_ctrl.

Test Plan:
1. Issue rd = 5, then next cycle dec_rs1 = 5 with use_rs1 -> dec_ready = 0 until the cycle after wb_valid/wb_rd = 5; with the bypass defined, ready in the wb cycle itself.
2. Issue rd = 0 with rs1 = 0 back-to-back -> never stalls, pending_mask stays 0, outstanding stays 0.
3. Issue rd = 1,2,3,4 (MAX_OUT = 4), then rd = 6 -> stalled on full; wb_rd = 2 -> issue of rd = 6 the following cycle, outstanding = 4.
4. Issue rd = 7, then a dec_wr_rd instruction with rd = 7 and no source use -> WAW stall until wb_rd = 7.
5. Two in flight, pulse drain_req -> drain_busy = 1 and dec_ready = 0; after both wb_valid, drain_done pulses once, then issue resumes.
6. Assert rst mid-DRAIN with outstanding = 2 -> all outputs 0 immediately, no drain_done; flush with a valid hazard-free instr -> issue_fire = 0.
